// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU, branch resolution and an
// iterative RV32M unit enabled by EX_MULDIV_EN (stall tied low when undefined).
module ex_stage #(
    parameter int XLEN    = 32,
    parameter int MD_ITER = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_regs_data1,
    input  logic [XLEN-1:0] ex_regs_data2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [2:0]      ex_func3_code,
    input  logic            ex_func7_code,
    input  logic [2:0]      ex_alu_op,
    input  logic [1:0]      ex_alu_src1,
    input  logic [1:0]      ex_alu_src2,
    input  logic            ex_br,
    input  logic            ex_jump,
    input  logic            ex_br_addr_mode,
    input  logic            ex_muldiv,
    input  logic [4:0]      ex_rs1,
    input  logic [4:0]      ex_rs2,
    input  logic            mem_regs_write,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic            wb_regs_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_flush,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_br_taken,
    output logic [XLEN-1:0] ex_br_target,
    output logic            ex_stall
);

    logic [XLEN-1:0] fwd1, fwd2, src1, src2, alu_res, br_sum;
    logic            cond;

    // MEM beats WB; x0 is never forwarded
    always_comb begin
        fwd1 = ex_regs_data1;
        if (mem_regs_write && mem_rd != 5'd0 && mem_rd == ex_rs1)
            fwd1 = mem_alu_result;
        else if (wb_regs_write && wb_rd != 5'd0 && wb_rd == ex_rs1)
            fwd1 = wb_data;
    end

    always_comb begin
        fwd2 = ex_regs_data2;
        if (mem_regs_write && mem_rd != 5'd0 && mem_rd == ex_rs2)
            fwd2 = mem_alu_result;
        else if (wb_regs_write && wb_rd != 5'd0 && wb_rd == ex_rs2)
            fwd2 = wb_data;
    end

    always_comb begin
        src1 = '0;
        unique case (ex_alu_src1)
            2'b00:   src1 = fwd1;
            2'b01:   src1 = ex_pc;
            default: src1 = '0;
        endcase
    end

    always_comb begin
        src2 = '0;
        unique case (ex_alu_src2)
            2'b00:   src2 = fwd2;
            2'b01:   src2 = ex_imm;
            2'b10:   src2 = XLEN'(4);
            default: src2 = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (ex_alu_op)
            3'b000: alu_res = src1 + src2;
            3'b001, 3'b010: begin
                unique case (ex_func3_code)
                    3'b000: alu_res = (ex_alu_op == 3'b001 && ex_func7_code)
                                      ? src1 - src2 : src1 + src2;
                    3'b001: alu_res = src1 << src2[4:0];
                    3'b010: alu_res = XLEN'($signed(src1) < $signed(src2));
                    3'b011: alu_res = XLEN'(src1 < src2);
                    3'b100: alu_res = src1 ^ src2;
                    3'b101: alu_res = ex_func7_code
                                      ? XLEN'($signed(src1) >>> src2[4:0])
                                      : src1 >> src2[4:0];
                    3'b110: alu_res = src1 | src2;
                    default: alu_res = src1 & src2;
                endcase
            end
            3'b011:  alu_res = src1 - src2;
            3'b100:  alu_res = src2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        unique case (ex_func3_code)
            3'b000:  cond = fwd1 == fwd2;
            3'b001:  cond = fwd1 != fwd2;
            3'b100:  cond = $signed(fwd1) <  $signed(fwd2);
            3'b101:  cond = $signed(fwd1) >= $signed(fwd2);
            3'b110:  cond = fwd1 <  fwd2;
            3'b111:  cond = fwd1 >= fwd2;
            default: cond = 1'b0;
        endcase
    end

    assign br_sum        = fwd1 + ex_imm;
    assign ex_br_taken   = ex_jump | (ex_br & cond);
    assign ex_br_target  = ex_br_addr_mode ? {br_sum[XLEN-1:1], 1'b0}
                                           : ex_pc + ex_imm;
    assign ex_store_data = fwd2;

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

    localparam int CW = $clog2(MD_ITER) + 1;

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step, prod_s;
    logic [XLEN-1:0]   opb_q, opb_d, res_q, res_d;
    logic [XLEN-1:0]   a_mag, b_mag, quo_s, rem_s, md_fin;
    logic [XLEN:0]     msum, dsub;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic              a_sgn, b_sgn, is_div, md_stall;

    assign is_div = ex_func3_code[2];
    assign a_sgn  = fwd1[XLEN-1] & (ex_func3_code == 3'b001 ||
                    ex_func3_code == 3'b010 || ex_func3_code == 3'b100 ||
                    ex_func3_code == 3'b110);
    assign b_sgn  = fwd2[XLEN-1] & (ex_func3_code == 3'b001 ||
                    ex_func3_code == 3'b100 || ex_func3_code == 3'b110);
    assign a_mag  = a_sgn ? -fwd1 : fwd1;
    assign b_mag  = b_sgn ? -fwd2 : fwd2;

    // acc holds {hi, lo} for mul and {rem, quo} for div
    always_comb begin
        msum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        dsub = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        step = {msum, acc_q[XLEN-1:1]};
        if (op_q[2])
            step = dsub[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {dsub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod_s = neg_q ? -step : step;
        quo_s  = dz_q ? '1 : (neg_q ? -step[XLEN-1:0] : step[XLEN-1:0]);
        rem_s  = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        if (op_q[2])
            md_fin = op_q[1] ? rem_s : quo_s;
        else
            md_fin = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                          : prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        res_d    = res_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        md_stall = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (ex_muldiv && !ex_flush) begin
                    md_stall = 1'b1;
                    op_d     = ex_func3_code;
                    acc_d    = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                    opb_d    = is_div ? b_mag : a_mag;
                    neg_d    = a_sgn ^ b_sgn;
                    rneg_d   = a_sgn;
                    dz_d     = is_div && fwd2 == '0;
                    cnt_d    = '0;
                    state_d  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (ex_flush) begin
                    state_d = MD_IDLE;
                end else begin
                    md_stall = 1'b1;
                    acc_d    = step;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(MD_ITER - 1)) begin
                        res_d   = md_fin;
                        state_d = MD_DONE;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign ex_stall  = md_stall & rstn;
    assign ex_result = (state_q == MD_DONE && !ex_flush) ? res_q : alu_res;
`else
    logic unused_ok;

    assign unused_ok = ^{clk, rstn, ex_muldiv} ^ (MD_ITER == 0);
    assign ex_stall  = 1'b0;
    assign ex_result = alu_res;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage; mul/div scenarios run when EX_MULDIV_EN
// is defined, otherwise the bench checks that ex_muldiv is ignored.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ex_pc, ex_regs_data1, ex_regs_data2, ex_imm;
    logic [2:0]  ex_func3_code, ex_alu_op;
    logic        ex_func7_code;
    logic [1:0]  ex_alu_src1, ex_alu_src2;
    logic        ex_br, ex_jump, ex_br_addr_mode, ex_muldiv;
    logic [4:0]  ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic        mem_regs_write, wb_regs_write, ex_flush;
    logic [31:0] mem_alu_result, wb_data;
    logic [31:0] ex_result, ex_store_data, ex_br_target;
    logic        ex_br_taken, ex_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rstn(rstn), .ex_pc(ex_pc),
        .ex_regs_data1(ex_regs_data1), .ex_regs_data2(ex_regs_data2),
        .ex_imm(ex_imm), .ex_func3_code(ex_func3_code),
        .ex_func7_code(ex_func7_code), .ex_alu_op(ex_alu_op),
        .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
        .ex_br(ex_br), .ex_jump(ex_jump), .ex_br_addr_mode(ex_br_addr_mode),
        .ex_muldiv(ex_muldiv), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .mem_regs_write(mem_regs_write), .mem_rd(mem_rd),
        .mem_alu_result(mem_alu_result), .wb_regs_write(wb_regs_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush),
        .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_stall(ex_stall)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_pc = 0; ex_regs_data1 = 0; ex_regs_data2 = 0; ex_imm = 0;
        ex_func3_code = 0; ex_func7_code = 0; ex_alu_op = 0;
        ex_alu_src1 = 0; ex_alu_src2 = 0; ex_br = 0; ex_jump = 0;
        ex_br_addr_mode = 0; ex_muldiv = 0; ex_rs1 = 0; ex_rs2 = 0;
        mem_regs_write = 0; mem_rd = 0; mem_alu_result = 0;
        wb_regs_write = 0; wb_rd = 0; wb_data = 0; ex_flush = 0;
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] rs,
                                          input logic [31:0] rf);
        if (rs != 0 && mem_regs_write && mem_rd == rs) return mem_alu_result;
        if (rs != 0 && wb_regs_write && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] op,
        input logic [2:0] f3, input logic f7, input logic [31:0] a, b);
        int sa, sb;
        sa = a; sb = b;
        if (op == 3'b000) return a + b;
        if (op == 3'b100) return b;
        case (f3)
            3'd0: return (op == 3'b001 && f7) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return (sa < sb) ? 1 : 0;
            3'd3: return (a < b) ? 1 : 0;
            3'd4: return a ^ b;
            3'd5: return f7 ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic m_cond(input logic [2:0] f3,
                                    input logic [31:0] a, b);
        int sa, sb;
        sa = a; sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_md(input logic [2:0] f3,
                                         input logic [31:0] a, b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        logic ovf;
        sa = a; sb = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        case (f3)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // one mul/div op; stall cycles counted, result checked in DONE
    task automatic md_run(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, b);
        int n;
        int fsel;
        logic [31:0] exp;
        exp = m_md(f3, a, b);
        @(posedge clk); #1;
        idle_inputs();
        ex_muldiv = 1; ex_alu_op = 3'b001; ex_func3_code = f3;
        ex_rs1 = 1; ex_rs2 = 2;
        ex_regs_data1 = a; ex_regs_data2 = b;
        fsel = $urandom_range(0, 2);
        if (fsel == 1) begin
            mem_regs_write = 1; mem_rd = 1; mem_alu_result = a;
            ex_regs_data1 = $urandom;
        end else if (fsel == 2) begin
            wb_regs_write = 1; wb_rd = 2; wb_data = b;
            ex_regs_data2 = $urandom;
        end
        n = 0;
        @(negedge clk);
        while (ex_stall && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (n == 1) begin
                mem_alu_result = $urandom; wb_data = $urandom;
                ex_regs_data1 = $urandom; ex_regs_data2 = $urandom;
            end
            @(negedge clk);
        end
        check({tag, "_lat"}, n, 33);
        check({tag, "_res"}, ex_result, exp);
        @(posedge clk); #1;
        ex_muldiv = 0;
    endtask

    initial begin
        logic [31:0] a, b, s1, s2;
        logic [2:0]  ops [4];
        logic        seen;
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100;

        idle_inputs();
        rstn = 0;
        ex_muldiv = 1; ex_alu_op = 3'b100; ex_alu_src2 = 2'b01;
        ex_imm = 32'h1234;
        #12;
        check("rst_stall", ex_stall, 0);
        check("rst_res", ex_result, 32'h1234);
        @(posedge clk); #1;
        rstn = 1;
        idle_inputs();

        // forwarding priority
        ex_rs1 = 5; ex_regs_data1 = 32'h30; ex_alu_src2 = 2'b01; ex_imm = 1;
        mem_regs_write = 1; mem_rd = 5; mem_alu_result = 32'h10;
        wb_regs_write = 1; wb_rd = 5; wb_data = 32'h20;
        @(negedge clk);
        check("fwd_mem", ex_result, 32'h11);
        mem_rd = 0;
        @(negedge clk);
        check("fwd_wb", ex_result, 32'h21);
        ex_rs1 = 0; wb_rd = 0; ex_regs_data1 = 32'h40;
        @(negedge clk);
        check("fwd_x0", ex_result, 32'h41);

        // BLT / BLTU
        idle_inputs();
        ex_alu_op = 3'b011; ex_br = 1; ex_func3_code = 3'b100;
        ex_rs1 = 1; ex_rs2 = 2; ex_regs_data1 = 32'hFFFF_FFFF;
        ex_regs_data2 = 1; ex_pc = 32'h100; ex_imm = 32'h40;
        @(negedge clk);
        check("blt_tkn", ex_br_taken, 1);
        check("blt_tgt", ex_br_target, 32'h140);
        ex_func3_code = 3'b110;
        @(negedge clk);
        check("bltu_tkn", ex_br_taken, 0);

        // JALR
        idle_inputs();
        ex_jump = 1; ex_br_addr_mode = 1; ex_rs1 = 3;
        ex_regs_data1 = 32'h203; ex_imm = 4; ex_pc = 32'h80;
        ex_alu_src1 = 2'b01; ex_alu_src2 = 2'b10;
        @(negedge clk);
        check("jalr_tkn", ex_br_taken, 1);
        check("jalr_tgt", ex_br_target, 32'h206);
        check("jalr_res", ex_result, 32'h84);

        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            ex_pc = $urandom; ex_regs_data1 = pick_op();
            ex_regs_data2 = pick_op(); ex_imm = $urandom;
            if ($urandom_range(0, 3) == 0) ex_regs_data2 = ex_regs_data1;
            ex_func3_code = 3'($urandom_range(0, 7));
            ex_func7_code = 1'($urandom_range(0, 1));
            ex_alu_op = ops[$urandom_range(0, 3)];
            ex_alu_src1 = 2'($urandom_range(0, 2));
            ex_alu_src2 = 2'($urandom_range(0, 2));
            ex_br = 1'($urandom_range(0, 1));
            ex_jump = ($urandom_range(0, 3) == 0);
            ex_br_addr_mode = 1'($urandom_range(0, 1));
            ex_rs1 = 5'($urandom_range(0, 3));
            ex_rs2 = 5'($urandom_range(0, 3));
            mem_regs_write = 1'($urandom_range(0, 1));
            mem_rd = 5'($urandom_range(0, 3)); mem_alu_result = $urandom;
            wb_regs_write = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
`ifdef EX_MULDIV_EN
            ex_muldiv = 0;
`else
            ex_muldiv = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
            a = m_fwd(ex_rs1, ex_regs_data1);
            b = m_fwd(ex_rs2, ex_regs_data2);
            s1 = (ex_alu_src1 == 0) ? a : (ex_alu_src1 == 1) ? ex_pc : 0;
            s2 = (ex_alu_src2 == 0) ? b : (ex_alu_src2 == 1) ? ex_imm : 4;
            check("r_res", ex_result,
                  m_alu(ex_alu_op, ex_func3_code, ex_func7_code, s1, s2));
            check("r_st", ex_store_data, b);
            check("r_tkn", ex_br_taken,
                  ex_jump | (ex_br & m_cond(ex_func3_code, a, b)));
            check("r_tgt", ex_br_target, ex_br_addr_mode
                  ? ((a + ex_imm) & 32'hFFFF_FFFE) : ex_pc + ex_imm);
            check("r_stall", ex_stall, 0);
        end

`ifdef EX_MULDIV_EN
        md_run("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
        md_run("mul", 3'd0, 32'h8000_0000, 32'h8000_0000);
        md_run("div0", 3'd4, 7, 0);
        md_run("rem0", 3'd6, 7, 0);
        md_run("ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        md_run("remu", 3'd7, 100, 7);
        for (int i = 0; i < 16; i++)
            md_run("md_rnd", 3'($urandom_range(0, 7)), pick_op(), pick_op());

        // flush in BUSY cycle 10
        @(posedge clk); #1;
        idle_inputs();
        ex_muldiv = 1; ex_func3_code = 3'd5; ex_rs1 = 1; ex_rs2 = 2;
        ex_regs_data1 = 1000; ex_regs_data2 = 3;
        ex_alu_src2 = 2'b01; ex_imm = 5;
        @(negedge clk);
        check("fl_start", ex_stall, 1);
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1 ex_flush = 1;
        @(negedge clk);
        check("fl_now", ex_stall, 0);
        @(posedge clk); #1;
        ex_flush = 0; ex_muldiv = 0;
        @(negedge clk);
        check("fl_next", ex_stall, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ex_result !== 32'd1005 || ex_stall) seen = 1;
        end
        check("fl_idle", seen, 0);
        md_run("fl_after", 3'd5, 1000, 3);

        // async reset mid-BUSY
        @(posedge clk); #1;
        idle_inputs();
        ex_muldiv = 1; ex_func3_code = 3'd0; ex_rs1 = 1; ex_rs2 = 2;
        ex_regs_data1 = 3; ex_regs_data2 = 5;
        for (int i = 0; i < 6; i++) @(posedge clk);
        #2 rstn = 0;
        #1 check("rst_busy", ex_stall, 0);
        @(posedge clk); #1;
        rstn = 1; ex_muldiv = 0;
        @(negedge clk);
        check("rst_after", ex_stall, 0);
        md_run("rst_run", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
        @(posedge clk); #1;
        idle_inputs();
        ex_muldiv = 1; ex_alu_op = 3'b001; ex_func3_code = 3'd0;
        ex_rs1 = 1; ex_rs2 = 2; ex_regs_data1 = 7; ex_regs_data2 = 9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nomd_stall", ex_stall, 0);
            check("nomd_res", ex_result, 16);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
